// File: rtl/load_use_scoreboard_pkg.sv
// Shared defaults for the register write scoreboard.
// Every module in the slice imports these so the top and the matcher agree on widths.
package load_use_scoreboard_pkg;
  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int MAX_PENDING    = 4;
  localparam int CNT_WIDTH      = 3;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;
endpackage

// File: rtl/load_use_scoreboard_match.sv
// Hazard detector for a single register index against the busy vector.
// A writeback landing on the same index this cycle is forwarded, so it cancels the hazard.
module scoreboard_match
  import load_use_scoreboard_pkg::*;
#(
  parameter int NREGS = NUM_REGS,
  parameter int AW    = REG_ADDR_WIDTH
) (
  input  logic [NREGS-1:0] i_busy,
  input  logic [AW-1:0]    i_idx,
  input  logic             i_use,
  input  logic             i_wb_valid,
  input  logic [AW-1:0]    i_wb_rd,
  output logic             o_hazard
);
  logic w_busy;
  logic w_wb_hit;

  assign w_busy   = i_busy[i_idx];
  assign w_wb_hit = i_wb_valid && (i_wb_rd == i_idx) && w_busy;
  assign o_hazard = i_use && w_busy && !w_wb_hit;
endmodule

// File: rtl/load_use_scoreboard.sv
// Tracks outstanding register writes (including variable-latency loads) and stalls
// decode on RAW/WAW hazards or when the outstanding-write budget is used up.
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
#(
  parameter int NUM_REGS_P       = NUM_REGS,
  parameter int REG_ADDR_WIDTH_P = REG_ADDR_WIDTH,
  parameter int MAX_PENDING_P    = MAX_PENDING,
  parameter int CNT_WIDTH_P      = CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic [REG_ADDR_WIDTH_P-1:0] issue_rs1,
  input  logic [REG_ADDR_WIDTH_P-1:0] issue_rs2,
  input  logic                        issue_uses_rs1,
  input  logic                        issue_uses_rs2,
  input  logic [REG_ADDR_WIDTH_P-1:0] issue_rd,
  input  logic                        issue_writes_rd,
  input  logic                        wb_valid,
  input  logic [REG_ADDR_WIDTH_P-1:0] wb_rd,
  input  logic                        flush,
  output logic                        stall,
  output logic [CNT_WIDTH_P-1:0]      pending_count,
  output logic                        full,
  output logic                        wb_error
);
  // Handshake: issue_valid is decode's request; the instruction issues on a rising
  // edge where issue_valid && !stall && !flush, otherwise decode holds it unchanged.
  logic [NUM_REGS_P-1:0]  r_busy;
  logic [CNT_WIDTH_P-1:0] r_pending_count;
  logic                   r_full;
  logic                   r_wb_error;

  logic                   w_raw1, w_raw2, w_waw;
  logic                   w_tracked, w_wb_hit, w_room, w_accept;
  logic [NUM_REGS_P-1:0]  w_set, w_clr, w_busy_next;
  logic [CNT_WIDTH_P-1:0] w_count_next;

  assign w_tracked = issue_writes_rd && (issue_rd != ZERO_REG[REG_ADDR_WIDTH_P-1:0]);

  scoreboard_match #(.NREGS(NUM_REGS_P), .AW(REG_ADDR_WIDTH_P)) u_match_rs1 (
    .i_busy(r_busy), .i_idx(issue_rs1), .i_use(issue_uses_rs1),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .o_hazard(w_raw1)
  );
  scoreboard_match #(.NREGS(NUM_REGS_P), .AW(REG_ADDR_WIDTH_P)) u_match_rs2 (
    .i_busy(r_busy), .i_idx(issue_rs2), .i_use(issue_uses_rs2),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .o_hazard(w_raw2)
  );
  scoreboard_match #(.NREGS(NUM_REGS_P), .AW(REG_ADDR_WIDTH_P)) u_match_rd (
    .i_busy(r_busy), .i_idx(issue_rd), .i_use(w_tracked),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .o_hazard(w_waw)
  );

  assign w_wb_hit = wb_valid && r_busy[wb_rd];
  // A retiring write this cycle frees its budget slot in time for the new issue.
  assign w_room   = (r_pending_count < CNT_WIDTH_P'(MAX_PENDING_P)) || w_wb_hit;
  assign stall    = issue_valid && !flush && (w_raw1 || w_raw2 || w_waw || (w_tracked && !w_room));
  assign w_accept = issue_valid && !stall && !flush && w_tracked;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_accept) w_set[issue_rd] = 1'b1;
    if (w_wb_hit) w_clr[wb_rd]    = 1'b1;
    // Set after clear so an issue to the register retiring this cycle keeps it busy.
    w_busy_next    = (r_busy & ~w_clr) | w_set;
    w_busy_next[0] = 1'b0;
  end

  always_comb begin
    w_count_next = r_pending_count;
    if (w_accept && !w_wb_hit)      w_count_next = r_pending_count + CNT_WIDTH_P'(1);
    else if (!w_accept && w_wb_hit) w_count_next = r_pending_count - CNT_WIDTH_P'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy          <= '0;
      r_pending_count <= '0;
      r_full          <= 1'b0;
      r_wb_error      <= 1'b0;
    end else begin
      if (flush) begin
        r_busy          <= '0;
        r_pending_count <= '0;
        r_full          <= 1'b0;
      end else begin
        r_busy          <= w_busy_next;
        r_pending_count <= w_count_next;
        r_full          <= (w_count_next == CNT_WIDTH_P'(MAX_PENDING_P));
      end
      if (wb_valid && !w_wb_hit) r_wb_error <= 1'b1;
    end
  end

  assign pending_count = r_pending_count;
  assign full          = r_full;
  assign wb_error      = r_wb_error;
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard: the driver queues hand-computed expectations,
// a negedge monitor pops one per cycle and compares stall/full/wb_error/pending_count.
module tb_load_use_scoreboard;
  import load_use_scoreboard_pkg::*;

  logic       clk, reset;
  logic       issue_valid, issue_uses_rs1, issue_uses_rs2, issue_writes_rd;
  logic [4:0] issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic       wb_valid, flush;
  logic       stall, full, wb_error;
  logic [2:0] pending_count;

  logic [5:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         failures = 0;

  load_use_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .pending_count(pending_count), .full(full), .wb_error(wb_error)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, packed as {stall, full, wb_error, pending_count}
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [5:0] e, a;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {stall, full, wb_error, pending_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got stall=%b full=%b wb_error=%b count=%0d, want stall=%b full=%b wb_error=%b count=%0d",
                 nm, a[5], a[4], a[3], a[2:0], e[5], e[4], e[3], e[2:0]);
      end
    end
  end

  // Driver: apply one cycle of inputs, queue the expected outputs, advance one clock
  task automatic cyc(input string nm,
                     input logic iv, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2,
                     input logic [4:0] rd, input logic wr,
                     input logic wv, input logic [4:0] wrd, input logic fl,
                     input logic e_st, input logic [2:0] e_cnt,
                     input logic e_full, input logic e_err);
    issue_valid = iv;  issue_rs1 = r1; issue_uses_rs1 = u1;
    issue_rs2 = r2;    issue_uses_rs2 = u2;
    issue_rd = rd;     issue_writes_rd = wr;
    wb_valid = wv;     wb_rd = wrd;    flush = fl;
    exp_q.push_back({e_st, e_full, e_err, e_cnt});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0;
    issue_rd = 0; issue_writes_rd = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    @(posedge clk); #1;
    //  name            iv r1 u1 r2 u2 rd wr wv wrd fl  st cnt fu er
    cyc("in_reset",      1, 1, 1, 2, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    reset = 1'b1;
    cyc("idle_reads",    1, 1, 1, 2, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    cyc("load_r5",       1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 0, 0);
    cyc("use_r5_a",      1, 5, 1, 0, 0, 8, 0, 0, 0, 0,  1, 1, 0, 0);
    cyc("use_r5_b",      1, 5, 1, 0, 0, 8, 0, 0, 0, 0,  1, 1, 0, 0);
    cyc("use_r5_c",      1, 0, 0, 5, 1, 8, 0, 0, 0, 0,  1, 1, 0, 0);
    cyc("use_r5_wb",     1, 5, 1, 0, 0, 8, 0, 1, 5, 0,  0, 1, 0, 0);
    cyc("r5_cleared",    1, 5, 1, 5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    cyc("load_r1",       1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0);
    cyc("load_r2",       1, 0, 0, 0, 0, 2, 1, 0, 0, 0,  0, 1, 0, 0);
    cyc("load_r3",       1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 2, 0, 0);
    cyc("load_r4",       1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  0, 3, 0, 0);
    cyc("fifth_full",    1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  1, 4, 1, 0);
    cyc("fifth_wb_r2",   1, 0, 0, 0, 0, 6, 1, 1, 2, 0,  0, 4, 1, 0);
    cyc("rd0_write",     1, 0, 1, 0, 1, 0, 1, 0, 0, 0,  0, 4, 1, 0);
    cyc("r2_free",       1, 2, 1, 0, 0, 0, 0, 0, 0, 0,  0, 4, 1, 0);
    cyc("r6_busy",       1, 6, 1, 0, 0, 0, 0, 0, 0, 0,  1, 4, 1, 0);
    cyc("drain_r1",      0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 4, 1, 0);
    cyc("drain_r3",      0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 3, 0, 0);
    cyc("drain_r4",      0, 0, 0, 0, 0, 0, 0, 1, 4, 0,  0, 2, 0, 0);
    cyc("drain_r6",      0, 0, 0, 0, 0, 0, 0, 1, 6, 0,  0, 1, 0, 0);
    cyc("load_r7",       1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 0, 0);
    cyc("r7_set_wins",   1, 0, 0, 0, 0, 7, 1, 1, 7, 0,  0, 1, 0, 0);
    cyc("r7_still_busy", 1, 7, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    cyc("load_r3b",      1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 1, 0, 0);
    cyc("load_r9",       1, 0, 0, 0, 0, 9, 1, 0, 0, 0,  0, 2, 0, 0);
    cyc("flush_cycle",   1, 7, 1, 0, 0,10, 1, 0, 0, 1,  0, 3, 0, 0);
    cyc("after_flush",   1, 7, 1, 9, 1,10, 0, 0, 0, 0,  0, 0, 0, 0);
    cyc("stale_wb_r3",   0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 0, 0, 0);
    cyc("err_sticky_a",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    cyc("load_r11",      1, 0, 0, 0, 0,11, 1, 0, 0, 0,  0, 0, 0, 1);
    cyc("r11_raw",       1,11, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1);
    reset = 1'b0;
    cyc("async_reset",   1,11, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    reset = 1'b1;
    cyc("post_reset",    1,11, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);

    issue_valid = 0; wb_valid = 0; flush = 0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
